// File: rtl/pong_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// pong_round_ctrl_if
//
// Signal bundle between the Pong round/match sequencer and the rest of the game
// (VGA timing start-of-frame, collision block, score displays, debug LEDs).
//
// Modports:
//   master : the round controller (drives ball_on, new_round, serve_dir,
//            p1_score, p2_score, winner, state_dbg; receives frame_tick, start,
//            oob, oob_right and, with PONG_PAUSE_EN, pause)
//   slave  : the surrounding game logic (the mirror image of master)
//
// Signals:
//   frame_tick  1        one-cycle pulse at start of each frame
//   start       1        one-cycle player start/restart request
//   oob         1        ball out of bounds (level)
//   oob_right   1        valid with oob; 1 = right edge (P1 scores)
//   pause       1        one-cycle pause toggle (only with PONG_PAUSE_EN)
//   ball_on     1        ball visible and moving
//   new_round   1        one-cycle pulse: reset ball position/collision state
//   serve_dir   1        0 = serve left, 1 = serve right
//   p1_score    SCORE_W  player 1 score
//   p2_score    SCORE_W  player 2 score
//   winner      2        0 none, 1 P1, 2 P2
//   state_dbg   3        current controller state encoding
//
// Configuration macro: PONG_PAUSE_EN adds the pause signal.
// -----------------------------------------------------------------------------
interface pong_round_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic               oob;
    logic               oob_right;
`ifdef PONG_PAUSE_EN
    logic               pause;
`endif
    logic               ball_on;
    logic               new_round;
    logic               serve_dir;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [1:0]         winner;
    logic [2:0]         state_dbg;

    modport master (
`ifdef PONG_PAUSE_EN
        input  pause,
`endif
        input  frame_tick, start, oob, oob_right,
        output ball_on, new_round, serve_dir, p1_score, p2_score, winner, state_dbg
    );

    modport slave (
`ifdef PONG_PAUSE_EN
        output pause,
`endif
        output frame_tick, start, oob, oob_right,
        input  ball_on, new_round, serve_dir, p1_score, p2_score, winner, state_dbg
    );
endinterface

// File: rtl/pong_round_ctrl.sv
// -----------------------------------------------------------------------------
// pong_round_ctrl
//
// Round/match sequencer for Pong in the video clock domain. Owns the scores,
// the winner, the frame-counted serve delay and the ball enable, and tells the
// ball/collision datapath when a new round starts.
//
// Ports:
//   clk    in   video clock
//   reset  in   asynchronous, active-high
//   bus    pong_round_ctrl_if.master (see interface file for signal list)
//
// Parameters:
//   WIN_SCORE     score at which a player wins (1..2^SCORE_W-1)
//   SERVE_FRAMES  frames the ball stays hidden before each serve (>=1)
//   SCORE_W       width of each score register
//   CNT_W         width of the serve frame counter (must hold SERVE_FRAMES)
//
// Configuration macro: PONG_PAUSE_EN adds a pause toggle and a PAUSE state
// that freezes SERVE or PLAY and later resumes where it left off.
//
// Every output is a flop; nothing passes combinationally from an input.
// -----------------------------------------------------------------------------
module pong_round_ctrl #(
    parameter int WIN_SCORE    = 10,
    parameter int SERVE_FRAMES = 120,
    parameter int SCORE_W      = 4,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    pong_round_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
`ifdef PONG_PAUSE_EN
        , S_PAUSE = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               oob_right_q, oob_right_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               serve_dir_q, serve_dir_d;
    logic               ball_on_q, ball_on_d;
    logic               new_round_q, new_round_d;
`ifdef PONG_PAUSE_EN
    state_t             resume_q, resume_d;
`endif

    logic [CNT_W-1:0]   cnt_inc;
    logic [SCORE_W-1:0] p1_inc;
    logic [SCORE_W-1:0] p2_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign p1_inc  = p1_q + SCORE_W'(1);
    assign p2_inc  = p2_q + SCORE_W'(1);

    // NOTE: every variable is given a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        oob_right_d = oob_right_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        new_round_d = 1'b0;
`ifdef PONG_PAUSE_EN
        resume_d    = resume_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A frame_tick arriving together with start is not counted:
                // counting only happens once the state register shows SERVE.
                if (bus.start) begin
                    state_d = S_SERVE;
                    cnt_d   = '0;
                end
            end

            S_SERVE: begin
`ifdef PONG_PAUSE_EN
                if (bus.pause) begin
                    resume_d = S_SERVE;
                    state_d  = S_PAUSE;
                end else
`endif
                if (bus.frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == SERVE_LAST) begin
                        state_d     = S_PLAY;
                        new_round_d = 1'b1;
                    end
                end
            end

            S_PLAY: begin
`ifdef PONG_PAUSE_EN
                if (bus.pause) begin
                    resume_d = S_PLAY;
                    state_d  = S_PAUSE;
                end else
`endif
                // While new_round is high the collision block has not yet
                // cleared a stale oob from the previous point.
                if (bus.oob && !new_round_q) begin
                    state_d     = S_POINT;
                    oob_right_d = bus.oob_right;
                end
            end

            S_POINT: begin
                // The serve goes toward the player who conceded.
                serve_dir_d = oob_right_q;
                if (oob_right_q) begin
                    p1_d = p1_inc;
                end else begin
                    p2_d = p2_inc;
                end
                if (oob_right_q && (p1_inc == WIN_VAL)) begin
                    winner_d = 2'd1;
                    state_d  = S_OVER;
                end else if (!oob_right_q && (p2_inc == WIN_VAL)) begin
                    winner_d = 2'd2;
                    state_d  = S_OVER;
                end else begin
                    state_d = S_SERVE;
                    cnt_d   = '0;
                end
            end

            S_OVER: begin
                if (bus.start) begin
                    p1_d        = '0;
                    p2_d        = '0;
                    winner_d    = 2'd0;
                    serve_dir_d = 1'b0;
                    state_d     = S_SERVE;
                    cnt_d       = '0;
                end
            end

`ifdef PONG_PAUSE_EN
            S_PAUSE: begin
                // Resuming never pulses new_round: the ball keeps its position.
                if (bus.pause) begin
                    state_d = resume_q;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ball_on_d = (state_d == S_PLAY);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            oob_right_q <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            winner_q    <= 2'd0;
            serve_dir_q <= 1'b0;
            ball_on_q   <= 1'b0;
            new_round_q <= 1'b0;
`ifdef PONG_PAUSE_EN
            resume_q    <= S_IDLE;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            oob_right_q <= oob_right_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            winner_q    <= winner_d;
            serve_dir_q <= serve_dir_d;
            ball_on_q   <= ball_on_d;
            new_round_q <= new_round_d;
`ifdef PONG_PAUSE_EN
            resume_q    <= resume_d;
`endif
        end
    end

    assign bus.ball_on   = ball_on_q;
    assign bus.new_round = new_round_q;
    assign bus.serve_dir = serve_dir_q;
    assign bus.p1_score  = p1_q;
    assign bus.p2_score  = p2_q;
    assign bus.winner    = winner_q;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/pong_round_ctrl.md
# pong_round_ctrl

Round/match sequencer for the Pong game. It owns scores, winner, serve timing and ball enable, and sequences the ball-position and collision datapath. It replaces the free-running 50 MHz "seconds" counter with a frame-counted serve delay in the video clock domain. It sits between the VGA timing generator's start-of-frame pulse, the collision block's out-of-bounds flag, and the score displays.

## Interface
Parameters:
- WIN_SCORE, 10, score at which a player wins the match (1..2^SCORE_W-1)
- SERVE_FRAMES, 120, frames the ball stays hidden before each serve (>=1)
- SCORE_W, 4, width of each score register
- CNT_W, 8, width of serve frame counter (must hold SERVE_FRAMES)

Ports:
- clk  in  1  video clock
- reset  in  1  asynchronous, active-high; clock clk
- frame_tick  in  1  one-cycle pulse at start of each frame
- start  in  1  one-cycle pulse, player start/restart request
- oob  in  1  level, ball out of bounds (from collision block)
- oob_right  in  1  valid with oob; 1 = ball left via right edge (P1 scores), 0 = left edge (P2 scores)
- ball_on  out  1  ball visible and moving
- new_round  out  1  one-cycle pulse: reset ball position/collision state
- serve_dir  out  1  0 = serve left, 1 = serve right
- p1_score  out  SCORE_W  player 1 score
- p2_score  out  SCORE_W  player 2 score
- winner  out  2  0 none, 1 P1, 2 P2
- state_dbg  out  3  current state encoding, for LEDs

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4 (PAUSE=5 only with macro).
- Reset values: state IDLE, ball_on 0, new_round 0, serve_dir 0, scores 0, winner 0, serve counter 0.
- IDLE: ball_on 0. start -> SERVE, serve counter cleared.
- SERVE: ball_on 0. Counter increments on each frame_tick. When a tick brings the count to SERVE_FRAMES -> PLAY, and new_round pulses for exactly that transition cycle. oob ignored.
- PLAY: ball_on 1. oob=1 -> POINT, latching oob_right. start ignored.
- POINT (exactly one cycle): ball_on 0. Latched oob_right=1 -> p1_score+1, else p2_score+1. If the incremented score equals WIN_SCORE, winner <= 1 or 2 and -> OVER. Otherwise -> SERVE with counter cleared. serve_dir <= latched oob_right, so the serve goes toward the player who conceded.
- OVER: ball_on 0; scores and winner held. start -> scores 0, winner 0, serve_dir 0, -> SERVE.
- Scores never exceed WIN_SCORE; no wrap.
- Asynchronous reset in any state immediately forces all reset values. A pending new_round pulse is dropped.

## Timing
- All outputs registered; no combinational input->output paths.
- oob to ball_on low: 1 cycle (PLAY->POINT edge). Score update: 2 cycles after oob sampled high.
- Serve delay: new_round and ball_on rise on the same edge, on the cycle after the SERVE_FRAMES-th frame_tick seen in SERVE. A frame_tick on the entry cycle into SERVE is not counted.
- start and frame_tick in the same cycle in IDLE/OVER: transition to SERVE, tick not counted.
- oob still high on re-entry to PLAY is not re-sampled until the first PLAY cycle after new_round. The downstream block clears oob on new_round.

## Configuration
- PONG_PAUSE_EN defined:
  - Adds input port pause (1, one-cycle pulse) and state PAUSE.
  - pause in SERVE or PLAY -> PAUSE, remembering the origin state. ball_on 0 and the serve counter frozen.
  - pause in PAUSE returns to the origin state with no new_round pulse.
  - start and oob are ignored in PAUSE.
  - pause is ignored in IDLE, POINT and OVER.
- Undefined: no pause port, no PAUSE state, state_dbg never shows 5.

## Test plan
- Reset, start, SERVE_FRAMES=4, five frame_ticks -> new_round pulses once and ball_on=1 on the cycle after the 4th tick.
- PLAY, oob=1 with oob_right=1 -> ball_on 0 next cycle, p1_score 0->1 two cycles later, serve_dir=1, re-enters SERVE.
- p2_score=9, oob with oob_right=0 -> p2_score=10, winner=2, state OVER. A further start -> scores 0, winner 0, SERVE.
- start pulsed during PLAY and oob held during SERVE -> no state change, scores unchanged.
- Assert reset mid-SERVE with count=2 -> all outputs at reset values immediately, state_dbg=0.
- PONG_PAUSE_EN: pause during PLAY -> ball_on 0, state_dbg=5. Ten frame_ticks and an oob produce no score change. pause again -> PLAY, ball_on 1, no new_round pulse.
